// File: rtl/mips_single_cycle_cpu_pkg.sv
// mips_pkg: opcode/funct constants, ALU operation enum, control-signal
// struct and the instruction decoder shared by the single-cycle MIPS core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {ADD, SUB, AND, OR, SLT} alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    reg_dst;     // 1: write rd, 0: write rt
        logic    alu_src;     // 1: ALU B operand is sign-extended imm16
        logic    mem_write;
        logic    mem_to_reg;  // 1: writeback from data RAM
        logic    branch;
        logic    jump;
        alu_op_e alu_op;
    } ctrl_t;

    // Anything not recognised decodes to all-zero controls, so it only advances pc.
    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        c        = '0;
        c.alu_op = ADD;
        case (op)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                case (fn)
                    FN_ADD:  c.alu_op = ADD;
                    FN_SUB:  c.alu_op = SUB;
                    FN_AND:  c.alu_op = AND;
                    FN_OR:   c.alu_op = OR;
                    FN_SLT:  c.alu_op = SLT;
                    default: c.reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.alu_op = SUB;
            end
            OP_J: begin
                c.jump = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_single_cycle_cpu_if.sv
// Register-file access bus: two asynchronous read ports and one write port.
// The core drives it through the master modport, the register file serves it.
interface mips_single_cycle_cpu_if;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    modport master (
        output rs_addr, rt_addr, wr_en, wr_addr, wr_data,
        input  rs_data, rt_data
    );

    modport slave (
        input  rs_addr, rt_addr, wr_en, wr_addr, wr_data,
        output rs_data, rt_data
    );
endinterface

// File: rtl/mips_single_cycle_cpu_regfile.sv
// mips_regfile: 32x32 register file, cleared by asynchronous active-low reset.
// r0 is hard-wired to zero on both the write and the read side. Reads return
// the pre-edge value, so a same-cycle write is not forwarded.
module mips_regfile (
    input  logic                           clk,
    input  logic                           rst,
    mips_single_cycle_cpu_if.slave         rf
);

    logic [31:0] regs_q [32];

    // Register array update: clear on reset, drop writes aimed at r0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf.wr_en && (rf.wr_addr != 5'd0)) begin
            regs_q[rf.wr_addr] <= rf.wr_data;
        end
    end

    assign rf.rs_data = (rf.rs_addr == 5'd0) ? '0 : regs_q[rf.rs_addr];
    assign rf.rt_data = (rf.rt_addr == 5'd0) ? '0 : regs_q[rf.rt_addr];

endmodule

// File: rtl/mips_single_cycle_cpu.sv
// mips_single_cycle_cpu: single-cycle MIPS core (add, sub, and, or, slt,
// addi, lw, sw, beq, j). ROM, data RAM, ALU and decode live here; the
// register file is the mips_regfile sub-module.
// Optional feature: define CPU_TRACE_EN for a per-cycle commit trace
// (simulation only); without it no trace code is compiled.
module mips_single_cycle_cpu
    import mips_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
    parameter logic [31:0] DATA_BASE = 32'h0000_0000,
    parameter int          IM_DEPTH  = 1024,
    parameter int          DM_DEPTH  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    output logic [31:0] inst
);

    localparam int IM_AW = $clog2(IM_DEPTH);
    localparam int DM_AW = $clog2(DM_DEPTH);

    // Instruction ROM is loaded from outside (bench / memory init flow).
    logic [31:0] rom_mem [IM_DEPTH];
    logic [31:0] dmem_q  [DM_DEPTH];

    logic [31:0]        pc_q, pc_d;
    logic [31:0]        pc_plus4, br_target, j_target;
    logic [29:0]        im_idx;
    logic [DM_AW-1:0]   dm_idx;
    logic [5:0]         op, fn;
    logic [4:0]         rs, rt, rd;
    logic [15:0]        imm;
    logic [25:0]        target;
    logic [31:0]        imm_sext;
    ctrl_t              ctrl;
    logic signed [31:0] alu_a, alu_b, alu_y;
    logic [31:0]        mem_rdata;
    logic               take_branch;

    mips_single_cycle_cpu_if rf_bus ();

    mips_regfile u_rf (
        .clk (clk),
        .rst (rst),
        .rf  (rf_bus)
    );

    assign pc = pc_q;

    // Fetch: word index relative to TEXT_BASE; outside the ROM reads as zero.
    assign im_idx = 30'((pc_q - TEXT_BASE) >> 2);
    assign inst   = (im_idx < 30'(IM_DEPTH)) ? rom_mem[im_idx[IM_AW-1:0]] : '0;

    assign op       = inst[31:26];
    assign rs       = inst[25:21];
    assign rt       = inst[20:16];
    assign rd       = inst[15:11];
    assign fn       = inst[5:0];
    assign imm      = inst[15:0];
    assign target   = inst[25:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign ctrl     = decode(op, fn);

    assign rf_bus.rs_addr = rs;
    assign rf_bus.rt_addr = rt;

    assign alu_a = rf_bus.rs_data;
    assign alu_b = ctrl.alu_src ? imm_sext : rf_bus.rt_data;

    // ALU: wraparound add/sub, bitwise and/or, signed set-less-than.
    always_comb begin
        alu_y = alu_a + alu_b;
        case (ctrl.alu_op)
            ADD:     alu_y = alu_a + alu_b;
            SUB:     alu_y = alu_a - alu_b;
            AND:     alu_y = alu_a & alu_b;
            OR:      alu_y = alu_a | alu_b;
            SLT:     alu_y = {31'b0, (alu_a < alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    // Data RAM word index wraps modulo DM_DEPTH; low address bits are ignored.
    assign dm_idx    = DM_AW'(((alu_y - DATA_BASE) >> 2) % DM_DEPTH);
    assign mem_rdata = dmem_q[dm_idx];

    assign rf_bus.wr_en   = ctrl.reg_write;
    assign rf_bus.wr_addr = ctrl.reg_dst ? rd : rt;
    assign rf_bus.wr_data = ctrl.mem_to_reg ? mem_rdata : alu_y;

    assign pc_plus4    = pc_q + 32'd4;
    assign br_target   = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign j_target    = {pc_plus4[31:28], target, 2'b00};
    assign take_branch = ctrl.branch && (rf_bus.rs_data == rf_bus.rt_data);

    // Next-pc selection: jump, taken branch, or fall through.
    always_comb begin
        pc_d = pc_plus4;
        if (ctrl.jump) begin
            pc_d = j_target;
        end else if (take_branch) begin
            pc_d = br_target;
        end
    end

    // Program counter: reset to TEXT_BASE, otherwise advance every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= TEXT_BASE;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Data RAM store; suppressed while the core is held in reset.
    always_ff @(posedge clk) begin
        if (rst && ctrl.mem_write) begin
            dmem_q[dm_idx] <= rf_bus.rt_data;
        end
    end

`ifdef CPU_TRACE_EN
    // Commit trace: pc, instruction and any register/memory write this cycle.
    always @(posedge clk) begin
        if (rst) begin
            $display("[trace] pc=%08h inst=%08h", pc_q, inst);
            if (rf_bus.wr_en && (rf_bus.wr_addr != 5'd0)) begin
                $display("[trace]   r%0d <= %08h", rf_bus.wr_addr, rf_bus.wr_data);
            end
            if (ctrl.mem_write) begin
                $display("[trace]   mem[%08h] <= %08h", alu_y, rf_bus.rt_data);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
// Bench for mips_single_cycle_cpu: loads short programs into the ROM,
// checks the pc trace through an expected-value queue and the final
// register/memory state through tables of expected records.
module tb_mips_single_cycle_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc;
    logic [31:0] inst;

    mips_single_cycle_cpu dut (
        .clk  (clk),
        .rst  (rst),
        .pc   (pc),
        .inst (inst)
    );

    always #5 clk = ~clk;

    typedef enum int {K_REG, K_MEM, K_PC, K_INST} kind_e;
    typedef struct {
        string       name;
        kind_e       kind;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] prog_q[$];
    logic [31:0] exp_pc_q[$];
    vec_t        vecs[$];

    // Instruction encoders (independent of the design package)
    function automatic logic [31:0] f_r(int fn, int rd, int rs, int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction
    function automatic logic [31:0] f_i(int op, int rt, int rs, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] f_j(int tgt);
        return {6'h02, 26'(tgt)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic logic [31:0] probe(input kind_e k, input int idx);
        case (k)
            K_REG:   return dut.u_rf.regs_q[idx];
            K_MEM:   return dut.dmem_q[idx];
            K_PC:    return pc;
            default: return inst;
        endcase
    endfunction

    task automatic apply_vecs();
        foreach (vecs[i]) check(vecs[i].name, probe(vecs[i].kind, vecs[i].idx), vecs[i].exp);
        vecs.delete();
    endtask

    task automatic load_rom();
        for (int i = 0; i < 1024; i++) dut.rom_mem[i] = 32'h0;
        foreach (prog_q[i]) dut.rom_mem[i] = prog_q[i];
    endtask

    task automatic regs_zero_check(input string name);
        int nz;
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.u_rf.regs_q[i] !== 32'h0) nz++;
        check(name, 32'(nz), 32'h0);
    endtask

    // Asynchronous reset mid-run, reload ROM, release just after a rising edge.
    task automatic restart();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_rst_pc", pc, 32'h0000_3000);
        regs_zero_check("async_rst_regs");
        load_rom();
        #1;
        check("rst_inst", inst, prog_q[0]);
        @(posedge clk);
        #3 rst = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (exp_pc_q.size() > 0) check("pc_trace", pc, exp_pc_q.pop_front());
        end
        if (exp_pc_q.size() > 0) begin
            check("pc_trace_leftover", 32'(exp_pc_q.size()), 32'h0);
            exp_pc_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Arithmetic, memory and r0 program
        prog_q = '{
            f_i(8'h08, 1, 0, 5),           // addi $1,$0,5
            f_i(8'h08, 2, 0, -3),          // addi $2,$0,-3
            f_r(8'h20, 3, 1, 2),           // add  $3,$1,$2
            f_r(8'h22, 4, 2, 1),           // sub  $4,$2,$1
            f_r(8'h2A, 5, 2, 1),           // slt  $5,$2,$1
            f_r(8'h24, 6, 1, 2),           // and  $6,$1,$2
            f_r(8'h25, 7, 1, 2),           // or   $7,$1,$2
            f_i(8'h2B, 1, 0, 80),          // sw   $1,80($0)
            f_i(8'h2B, 2, 0, 84),          // sw   $2,84($0)
            f_i(8'h23, 8, 0, 80),          // lw   $8,80($0)
            f_i(8'h08, 0, 0, 7)            // addi $0,$0,7
        };
        load_rom();
        #12;
        check("reset_pc", pc, 32'h0000_3000);
        check("reset_inst", inst, prog_q[0]);
        regs_zero_check("reset_regs");
        #6 rst = 1'b1;
        for (int k = 1; k <= 11; k++) exp_pc_q.push_back(32'h3000 + 32'(4 * k));
        run(11);
        vecs.push_back('{"r1_addi",     K_REG, 1,  32'h0000_0005});
        vecs.push_back('{"r2_addi_neg", K_REG, 2,  32'hFFFF_FFFD});
        vecs.push_back('{"r3_add",      K_REG, 3,  32'h0000_0002});
        vecs.push_back('{"r4_sub",      K_REG, 4,  32'hFFFF_FFF8});
        vecs.push_back('{"r5_slt",      K_REG, 5,  32'h0000_0001});
        vecs.push_back('{"r6_and",      K_REG, 6,  32'h0000_0005});
        vecs.push_back('{"r7_or",       K_REG, 7,  32'hFFFF_FFFD});
        vecs.push_back('{"r8_lw",       K_REG, 8,  32'h0000_0005});
        vecs.push_back('{"r0_zero",     K_REG, 0,  32'h0000_0000});
        vecs.push_back('{"dmem20",      K_MEM, 20, 32'h0000_0005});
        vecs.push_back('{"dmem21",      K_MEM, 21, 32'hFFFF_FFFD});
        apply_vecs();

        // Jump to 0x3010, then taken beq to 0x301C
        prog_q = '{
            f_i(8'h08, 1, 0, 5), f_i(8'h08, 2, 0, -3), f_j(26'hC04), 32'h0,
            f_i(8'h04, 1, 1, 2),           // 0x3010: beq $1,$1,+2
            f_i(8'h08, 12, 0, 1),          // 0x3014
            f_i(8'h08, 12, 0, 1),          // 0x3018
            32'h0
        };
        restart();
        exp_pc_q = '{32'h3004, 32'h3008, 32'h3010, 32'h301C};
        run(4);
        vecs.push_back('{"beq_taken_skip", K_REG, 12, 32'h0});
        apply_vecs();

        // Not-taken beq at 0x3010 falls through to 0x3014
        prog_q[4] = f_i(8'h04, 2, 1, 2);   // beq $1,$2,+2
        restart();
        exp_pc_q = '{32'h3004, 32'h3008, 32'h3010, 32'h3014, 32'h3018};
        run(5);
        vecs.push_back('{"beq_nt_fall", K_REG, 12, 32'h1});
        apply_vecs();

        // Sum 1..5 into $9, store to m[21], then jump past the ROM
        prog_q = '{
            f_i(8'h08, 10, 0, 5),          // 0x3000 addi $10,$0,5
            f_i(8'h08, 11, 0, 1),          // 0x3004 addi $11,$0,1
            f_r(8'h20, 9, 9, 11),          // 0x3008 add  $9,$9,$11
            f_i(8'h04, 10, 11, 3),         // 0x300C beq  $11,$10,+3
            f_i(8'h08, 11, 11, 1),         // 0x3010 addi $11,$11,1
            32'h0,                         // 0x3014 unsupported
            f_j(26'hC02),                  // 0x3018 j 0x3008
            f_i(8'h2B, 9, 0, 84),          // 0x301C sw   $9,84($0)
            f_j(26'h1000)                  // 0x3020 j 0x4000 (outside ROM)
        };
        restart();
        run(35);
        vecs.push_back('{"loop_r9",     K_REG, 9,  32'd15});
        vecs.push_back('{"loop_r11",    K_REG, 11, 32'd5});
        vecs.push_back('{"loop_r10",    K_REG, 10, 32'd5});
        vecs.push_back('{"loop_mem21",  K_MEM, 21, 32'd15});
        vecs.push_back('{"loop_pc",     K_PC,  0,  32'h0000_4024});
        vecs.push_back('{"rom_oob",     K_INST, 0, 32'h0});
        vecs.push_back('{"loop_r0",     K_REG, 0,  32'h0});
        apply_vecs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
